// File: rtl/mcycle_pkg.sv
// mcycle_pkg: op encodings, FSM states and default width shared by the multiply/divide unit.
package mcycle_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [1:0] OP_SMUL = 2'b00;
  localparam logic [1:0] OP_UMUL = 2'b01;
  localparam logic [1:0] OP_SDIV = 2'b10;
  localparam logic [1:0] OP_UDIV = 2'b11;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
endpackage

// File: rtl/mcycle_divider_core.sv
// mcycle_divider_core: one restoring-division step on magnitudes (partial remainder/quotient in -> out).
module mcycle_divider_core
  import mcycle_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] shifted, diff;
  logic fit;
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  // rem_in < divisor keeps the difference below 2^WIDTH, so the top bit is a clean borrow
  assign diff    = shifted - {1'b0, divisor};
  assign fit     = ~diff[WIDTH];
  assign rem_out = fit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], fit};
endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: multi-cycle signed/unsigned multiply and divide; divide datapath is built only
// when MCYCLE_DIV_EN is defined, otherwise divide ops complete in one cycle with zero results.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, mcand, hi_n, lo_n, res1_n, res2_n, mag1, mag2;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] prod, prod_c;
  logic s1, s2, sg1, sg2, accept, last, skip;
  assign sg1    = ~MCycleOp[0] & Operand1[WIDTH-1];
  assign sg2    = ~MCycleOp[0] & Operand2[WIDTH-1];
  assign mag1   = sg1 ? -Operand1 : Operand1;
  assign mag2   = sg2 ? -Operand2 : Operand2;
  assign accept = state != COMPUTE && Start && !RESET;
  assign last   = state == COMPUTE && cnt == CW'(WIDTH - 1);
  // hi:lo doubles as product accumulator (multiply) and remainder:quotient (divide)
  assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign prod   = {sum, lo[WIDTH-1:1]};
  assign prod_c = (s1 ^ s2) ? -{hi_n, lo_n} : {hi_n, lo_n};
`ifdef MCYCLE_DIV_EN
  logic div_q;
  logic [WIDTH-1:0] op1_q, drem, dquo;
  mcycle_divider_core #(.WIDTH(WIDTH)) u_div (
    .rem_in (hi),
    .quo_in (lo),
    .divisor(mcand),
    .rem_out(drem),
    .quo_out(dquo)
  );
  assign skip   = 1'b0;
  assign hi_n   = div_q ? drem : prod[2*WIDTH-1:WIDTH];
  assign lo_n   = div_q ? dquo : prod[WIDTH-1:0];
  assign res1_n = !div_q ? prod_c[WIDTH-1:0] : mcand == '0 ? '1 : (s1 ^ s2) ? -lo_n : lo_n;
  assign res2_n = !div_q ? prod_c[2*WIDTH-1:WIDTH] : mcand == '0 ? op1_q : s1 ? -hi_n : hi_n;
  always_ff @(posedge CLK) begin
    if (accept) begin
      div_q <= MCycleOp[1];
      op1_q <= Operand1;
    end
  end
`else
  assign skip   = MCycleOp[1];
  assign hi_n   = prod[2*WIDTH-1:WIDTH];
  assign lo_n   = prod[WIDTH-1:0];
  assign res1_n = prod_c[WIDTH-1:0];
  assign res2_n = prod_c[2*WIDTH-1:WIDTH];
`endif
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = RESET ? IDLE : (state == COMPUTE) ? (last ? DONE : COMPUTE) :
              Start ? (skip ? DONE : COMPUTE) : IDLE;
  end
  always_comb begin
    Busy = accept || (state == COMPUTE && !RESET);
    Done = state == DONE;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      Result1 <= '0;
      Result2 <= '0;
    end else if (accept) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= MCycleOp[1] ? mag1 : mag2;
      mcand <= MCycleOp[1] ? mag2 : mag1;
      s1    <= sg1;
      s2    <= sg2;
      if (skip) begin
        Result1 <= '0;
        Result2 <= '0;
      end
    end else if (state == COMPUTE) begin
      cnt <= cnt + 1'b1;
      hi  <= hi_n;
      lo  <= lo_n;
      if (last) begin
        Result1 <= res1_n;
        Result2 <= res2_n;
      end
    end
  end
endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed checks of multiply, divide (or its disabled form), start handling and reset.
module tb_mcycle_unit;
  import mcycle_pkg::*;
  logic CLK = 1'b0, RESET = 1'b1, Start = 1'b0, Busy, Done;
  logic [1:0] MCycleOp = OP_UMUL;
  logic [31:0] Operand1 = '0, Operand2 = '0, Result1, Result2;
  int checks = 0, errors = 0;
  mcycle_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );
  always #5 CLK = ~CLK;
`ifdef MCYCLE_DIV_EN
  localparam int DIV_LAT = 33;
  localparam bit DIV_ON = 1'b1;
`else
  localparam int DIV_LAT = 1;
  localparam bit DIV_ON = 1'b0;
`endif
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic b0, output logic bk);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    #1 b0 = Busy;
    lat = 0; bk = 1'b1;
    do begin
      @(negedge CLK);
      Start = 1'b0; lat++;
      #1 if (!Done && !Busy) bk = 1'b0;
    end while (!Done && lat < 100);
  endtask
  task automatic test_reset;
    RESET = 1'b1; Start = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", Done); end
    checks++; if (Result1 !== 32'h0) begin errors++; $display("FAIL reset_r1 got %h exp 0", Result1); end
    checks++; if (Result2 !== 32'h0) begin errors++; $display("FAIL reset_r2 got %h exp 0", Result2); end
    @(negedge CLK); RESET = 1'b0; Start = 1'b0;
    #1 checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", Busy); end
  endtask
  task automatic test_mul;
    logic [1:0] ops [4] = '{OP_SMUL, OP_UMUL, OP_SMUL, OP_UMUL};
    logic [31:0] av [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h12345678};
    logic [31:0] bv [4] = '{32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000010};
    logic [31:0] e1 [4] = '{32'hFFFFFFEB, 32'h00000001, 32'h00000006, 32'h23456780};
    logic [31:0] e2 [4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000, 32'h00000001};
    int lat; logic b0, bk;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], av[i], bv[i], lat, b0, bk);
      checks++; if (lat !== 33) begin errors++; $display("FAIL mul%0d_latency got %0d exp 33", i, lat); end
      checks++; if (Result1 !== e1[i]) begin errors++; $display("FAIL mul%0d_r1 got %h exp %h", i, Result1, e1[i]); end
      checks++; if (Result2 !== e2[i]) begin errors++; $display("FAIL mul%0d_r2 got %h exp %h", i, Result2, e2[i]); end
      if (i == 0) begin
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL mul_busy_cycle0 got %b exp 1", b0); end
        checks++; if (bk !== 1'b1) begin errors++; $display("FAIL mul_busy_compute got %b exp 1", bk); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mul_busy_done got %b exp 0", Busy); end
      end
    end
  endtask
  task automatic test_div;
    logic [1:0] ops [5] = '{OP_SDIV, OP_UDIV, OP_SDIV, OP_UDIV, OP_SDIV};
    logic [31:0] av [5] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd5, 32'hFFFFFFFB};
    logic [31:0] bv [5] = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] e1 [5] = '{32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e2 [5] = '{32'hFFFFFFFF, 32'd2, 32'h00000000, 32'd5, 32'hFFFFFFFB};
    int lat; logic b0, bk;
    logic [31:0] x1, x2;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], av[i], bv[i], lat, b0, bk);
      x1 = DIV_ON ? e1[i] : 32'h0;
      x2 = DIV_ON ? e2[i] : 32'h0;
      checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL div%0d_latency got %0d exp %0d", i, lat, DIV_LAT); end
      checks++; if (Result1 !== x1) begin errors++; $display("FAIL div%0d_r1 got %h exp %h", i, Result1, x1); end
      checks++; if (Result2 !== x2) begin errors++; $display("FAIL div%0d_r2 got %h exp %h", i, Result2, x2); end
    end
  endtask
  task automatic test_start_ignored;
    int lat = 0;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = OP_UMUL; Operand1 = 32'd3; Operand2 = 32'd5;
    do begin
      @(negedge CLK);
      lat++;
      Start = lat < 12 ? lat[0] : 1'b0;
      MCycleOp = 2'(lat);
      Operand1 = $urandom; Operand2 = $urandom;
      #1;
    end while (!Done && lat < 100);
    Start = 1'b0;
    checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_latency got %0d exp 33", lat); end
    checks++; if (Result1 !== 32'd15) begin errors++; $display("FAIL ignore_r1 got %h exp 0000000f", Result1); end
    checks++; if (Result2 !== 32'd0) begin errors++; $display("FAIL ignore_r2 got %h exp 0", Result2); end
  endtask
  task automatic test_back_to_back;
    int lat = 0;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = OP_UMUL; Operand1 = 32'd6; Operand2 = 32'd7;
    do begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin Operand1 = 32'd9; Operand2 = 32'd9; end
      #1;
    end while (!Done && lat < 100);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_first_latency got %0d exp 33", lat); end
    checks++; if (Result1 !== 32'd42) begin errors++; $display("FAIL b2b_first_r1 got %h exp 0000002a", Result1); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_in_done got %b exp 1", Busy); end
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (lat == 1) Start = 1'b0;
      #1;
    end while (!Done && lat < 100);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_second_latency got %0d exp 33", lat); end
    checks++; if (Result1 !== 32'd81) begin errors++; $display("FAIL b2b_second_r1 got %h exp 00000051", Result1); end
    checks++; if (Result2 !== 32'd0) begin errors++; $display("FAIL b2b_second_r2 got %h exp 0", Result2); end
  endtask
  task automatic test_reset_mid;
    int lat; logic b0, bk;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = OP_UMUL; Operand1 = 32'd7; Operand2 = 32'd8;
    for (int i = 1; i <= 10; i++) begin @(negedge CLK); Start = 1'b0; end
    RESET = 1'b1;
    #1 checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_forced got %b exp 0", Busy); end
    @(negedge CLK); RESET = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", Done); end
    checks++; if (Result1 !== 32'h0) begin errors++; $display("FAIL rst_mid_r1 got %h exp 0", Result1); end
    checks++; if (Result2 !== 32'h0) begin errors++; $display("FAIL rst_mid_r2 got %h exp 0", Result2); end
    do_op(OP_UMUL, 32'd7, 32'd8, lat, b0, bk);
    checks++; if (lat !== 33) begin errors++; $display("FAIL rst_after_latency got %0d exp 33", lat); end
    checks++; if (Result1 !== 32'd56) begin errors++; $display("FAIL rst_after_r1 got %h exp 00000038", Result1); end
  endtask
  initial begin
    test_reset;
    test_mul;
    test_div;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
